// File: rtl/alphamission_video_pkg.sv
// Shared video definitions: layer source encoding, palette address width,
// default transparent codes and palette address prefixes per layer.
package alphamission_video_pkg;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BG   = 2'd1,
    SRC_SPR  = 2'd2,
    SRC_SIDE = 2'd3
  } layer_src_t;

  localparam int          PAL_AW          = 11;
  localparam logic [3:0]  SIDE_TRANSP_DEF = 4'hF;
  localparam logic [3:0]  SPR_TRANSP_DEF  = 4'hF;

  localparam logic [2:0]  PAL_PFX_SIDE    = 3'b111;
  localparam logic [2:0]  PAL_PFX_SPR     = 3'b100;
  localparam logic [2:0]  PAL_PFX_BG      = 3'b000;

endpackage

// File: rtl/side_layer_color_mixer_delay_line.sv
// CK1-enabled shift register used to align the side layer colour code with
// the sprite/background streams; reset fills every tap with FILL.
module side_pixel_delay_line #(
  parameter int               DEPTH = 3,
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] FILL  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] tap_q [DEPTH];
  logic [WIDTH-1:0] tap_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      tap_d[i] = tap_q[i];
    end
    if (en) begin
      tap_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        tap_d[i] = tap_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tap_q[i] <= FILL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        tap_q[i] <= tap_d[i];
      end
    end
  end

  assign dout = tap_q[DEPTH-1];

endmodule

// File: rtl/side_layer_color_mixer.sv
// Side layer colour mixer: delays SD, resolves SIDE/SPR/BG priority and emits
// the palette address. Optional layer masking under `SIDE_LAYER_MASK_EN.
module side_layer_color_mixer
  import alphamission_video_pkg::*;
#(
  parameter int         SD_DELAY    = 3,
  parameter logic [3:0] SIDE_TRANSP = SIDE_TRANSP_DEF,
  parameter logic [3:0] SPR_TRANSP  = SPR_TRANSP_DEF
) (
  input  logic              clk,
  input  logic              VIDEO_RST,
  input  logic              CK1,
  input  logic [3:0]        SD,
  input  logic [7:0]        SPR_D,
  input  logic [7:0]        BG_D,
  input  logic              HBLANKn,
  input  logic              VBLANKn,
  input  logic [7:0]        VD_in,
  input  logic              COLREG_CSn,
  input  logic              VWE,
`ifdef SIDE_LAYER_MASK_EN
  input  logic [2:0]        LAYER_MASK,
`endif
  output logic [PAL_AW-1:0] PAL_A,
  output logic [1:0]        PAL_SRC,
  output logic              PIX_VALID
);

  // Register layout: [3:0] side palette bank, [4] SPR_OVER_SIDE.
  logic [4:0]        staging_q, staging_d;
  logic [4:0]        active_q,  active_d;
  logic              vwe_prev_q, vwe_prev_d;
  logic              hbl_prev_q, hbl_prev_d;
  logic [PAL_AW-1:0] pal_a_q, pal_a_d;
  layer_src_t        pal_src_q, pal_src_d;
  logic              pix_valid_q, pix_valid_d;

  logic              cpu_wr;
  logic              line_start;
  logic [3:0]        sd_dly;
  logic              side_op, spr_op, bg_op;
  layer_src_t        winner;
  logic              unused_vd;

  assign unused_vd = ^VD_in[7:5];

  function automatic layer_src_t pick_layer(input logic side_o,
                                            input logic spr_o,
                                            input logic bg_o,
                                            input logic spr_over_side);
    layer_src_t w;
    w = SRC_NONE;
    if (bg_o) w = SRC_BG;
    if (spr_over_side) begin
      if (side_o) w = SRC_SIDE;
      if (spr_o)  w = SRC_SPR;
    end else begin
      if (spr_o)  w = SRC_SPR;
      if (side_o) w = SRC_SIDE;
    end
    return w;
  endfunction

  side_pixel_delay_line #(
    .DEPTH (SD_DELAY),
    .WIDTH (4),
    .FILL  (SIDE_TRANSP)
  ) u_sd_delay (
    .clk  (clk),
    .rst  (VIDEO_RST),
    .en   (CK1),
    .din  (SD),
    .dout (sd_dly)
  );

  // CPU register path: strobe edge detect and line-boundary transfer.
  assign cpu_wr     = vwe_prev_q & ~VWE & ~COLREG_CSn;
  assign line_start = hbl_prev_q & ~HBLANKn;

  always_comb begin
    vwe_prev_d = VWE;
    hbl_prev_d = HBLANKn;
    staging_d  = staging_q;
    active_d   = active_q;
    if (cpu_wr)     staging_d = VD_in[4:0];
    if (line_start) active_d  = staging_q;
  end

  always_comb begin
    side_op = (sd_dly != SIDE_TRANSP);
    spr_op  = (SPR_D[3:0] != SPR_TRANSP);
    bg_op   = 1'b1;
`ifdef SIDE_LAYER_MASK_EN
    side_op = side_op & ~LAYER_MASK[2];
    spr_op  = spr_op  & ~LAYER_MASK[1];
    bg_op   = bg_op   & ~LAYER_MASK[0];
`endif
    winner  = pick_layer(side_op, spr_op, bg_op, active_q[4]);
  end

  // Output stage: blanking is taken straight from the inputs, not delayed.
  always_comb begin
    pal_a_d     = pal_a_q;
    pal_src_d   = pal_src_q;
    pix_valid_d = pix_valid_q;
    if (CK1) begin
      if (!HBLANKn || !VBLANKn) begin
        pal_a_d     = '0;
        pal_src_d   = SRC_NONE;
        pix_valid_d = 1'b0;
      end else begin
        pix_valid_d = 1'b1;
        pal_src_d   = winner;
        case (winner)
          SRC_SIDE: pal_a_d = {PAL_PFX_SIDE, active_q[3:0], sd_dly};
          SRC_SPR:  pal_a_d = {PAL_PFX_SPR, SPR_D};
          SRC_BG:   pal_a_d = {PAL_PFX_BG, BG_D};
          default:  pal_a_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (VIDEO_RST) begin
      vwe_prev_q  <= 1'b1;
      hbl_prev_q  <= 1'b0;
      staging_q   <= '0;
      active_q    <= '0;
      pal_a_q     <= '0;
      pal_src_q   <= SRC_NONE;
      pix_valid_q <= 1'b0;
    end else begin
      vwe_prev_q  <= vwe_prev_d;
      hbl_prev_q  <= hbl_prev_d;
      staging_q   <= staging_d;
      active_q    <= active_d;
      pal_a_q     <= pal_a_d;
      pal_src_q   <= pal_src_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  assign PAL_A     = pal_a_q;
  assign PAL_SRC   = pal_src_q;
  assign PIX_VALID = pix_valid_q;

endmodule
